mem_burst_arbiter: RTL and testbench
====================================

// Module: mem_burst_arbiter
// PURPOSE
// Shares one memory-controller burst interface among 2 frame writers and 2 frame readers
// (frame_fifo_write / frame_fifo_read instances), all on mem_clk. Round-robin grant over
// 4 requesters (W0,W1,R0,R1); only one burst is outstanding at a time. Routes data_req,
// read data and finish back to the granted requester only.
// PARAMETERS
// MEM_DATA_BITS  32  data width of the memory user interface
// ADDR_BITS      23  burst address width
// BUSRT_BITS     10  burst length width
// PORTS
// mem_clk                 in   1               user-interface clock; only clock
// rst                     in   1               synchronous, active-high reset
// wr_burst_req            in   2               per-writer burst request, held until its finish
// wr_burst_len            in   2*BUSRT_BITS    per-writer length, writer i at [i*BUSRT_BITS +: BUSRT_BITS]
// wr_burst_addr           in   2*ADDR_BITS     per-writer base address
// wr_burst_data           in   2*MEM_DATA_BITS per-writer write data
// wr_burst_data_req       out  2               data request to the granted writer only
// wr_burst_finish         out  2               finish pulse to the granted writer only
// rd_burst_req/len/addr   in   2/2*BUSRT_BITS/2*ADDR_BITS   same layout, readers
// rd_burst_data_valid     out  2               valid to the granted reader only
// rd_burst_data           out  MEM_DATA_BITS   mem_rd_burst_data broadcast
// rd_burst_finish         out  2               finish pulse to the granted reader only
// mem_wr_burst_req/len/addr     out 1/BUSRT_BITS/ADDR_BITS   to controller
// mem_wr_burst_data       out  MEM_DATA_BITS   granted writer's data
// mem_wr_burst_data_req   in   1 ; mem_wr_burst_finish in 1
// mem_rd_burst_req/len/addr     out 1/BUSRT_BITS/ADDR_BITS   to controller
// mem_rd_burst_data_valid in 1 ; mem_rd_burst_data in MEM_DATA_BITS ; mem_rd_burst_finish in 1
// grant                   out  2               granted index 0=W0 1=W1 2=R0 3=R1 (debug)
// busy                    out  1               1 from grant until release completes
// BEHAVIOUR
// - Reset (sync): state=S_IDLE, last=3 (W0 has first priority), all outputs 0.
// - S_IDLE: if any req, pick the first asserted in order last+1, last+2, ... (mod 4);
//   latch grant, len, addr; go to S_ISSUE. Otherwise stay.
// - S_ISSUE: mem_wr_burst_req (writer) or mem_rd_burst_req (reader) = 1 with the latched
//   len/addr; the other mem req = 0. Stay until the matching mem_*_finish = 1. In that
//   cycle drop mem req (registered, next edge) and go to S_RELEASE.
// - Finish routing is combinational: wr/rd_burst_finish[g] = mem finish while in S_ISSUE.
// - S_RELEASE: one cycle, ignores requests so the finished requester can drop req;
//   last<=grant; go to S_IDLE. Gap between bursts >= 2 cycles; grant latency from req
//   to mem req = 2 cycles.
// - Data routing is combinational: wr_burst_data_req[g] = mem_wr_burst_data_req,
//   mem_wr_burst_data = writer g's data, rd_burst_data_valid[g] = mem_rd_burst_data_valid;
//   all ungranted bits 0. In S_IDLE/S_RELEASE mem_wr_burst_data = 0.
// - Zero length (latched len==0): no mem request; S_ISSUE pulses finish[g] for 1 cycle
//   itself, then S_RELEASE.
// - Requester drops req mid-burst: ignored, the burst completes and finish is still pulsed.
// - Finish of the wrong direction (e.g. mem_rd_burst_finish while writer granted): ignored.
// - All 4 requests held continuously: the order is strictly W0,W1,R0,R1,W0...; no starvation.
// - Reset mid-burst: immediate return to S_IDLE, mem req drops next edge; controller
//   recovery is outside this block.
// STRUCTURE
// - Shared package/include: state codes (S_IDLE=0, S_ISSUE=1, S_RELEASE=2), requester
//   indices (IDX_W0..IDX_R1), and localparams ONE/ZERO as already used in the DDR3 blocks.
// - One sub-module: rr_pick4 (combinational: req[3:0], last[1:0] -> grant[1:0], any).
// - Top: FSM, latches and the routing muxes.
// TESTING
// - Single writer: W0 req, len=16, addr=0x100 -> mem_wr_burst_req rises 2 cycles later with
//   len 16 / addr 0x100; 16 data_req pulses reach only bit 0; finish reaches only bit 0.
// - Contention: W0,W1,R0,R1 requesting from reset -> grant sequence 0,1,2,3,0, each mem
//   req preceded by >=2 idle cycles.
// - Read routing: R1 len=8 -> 8 valid beats on rd_burst_data_valid[1] only; bit 0 stays 0.
// - Zero length: W1 len=0 -> no mem req; wr_burst_finish[1] 1-cycle pulse; busy returns to 0.
// - Spurious finish: mem_rd_burst_finish during a W0 burst -> no state change, no finish out.
// - Reset mid-burst: rst asserted during R0 data -> next edge all outputs 0, state S_IDLE;
//   next R0 req is granted normally.

Source files
------------

// File: rtl/mem_burst_arbiter_pkg.sv
// Shared state codes, requester indices and constants for the memory burst arbiter.
package mem_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] IDX_W0 = 2'd0;
  localparam logic [1:0] IDX_W1 = 2'd1;
  localparam logic [1:0] IDX_R0 = 2'd2;
  localparam logic [1:0] IDX_R1 = 2'd3;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  // Readers occupy indices 2 and 3, so the top index bit selects direction.
  function automatic logic is_reader(input logic [1:0] idx);
    return idx[1];
  endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_pick4.sv
// Combinational round-robin picker over four requesters, searching from last+1 upward.
module rr_pick4
  import mem_burst_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    grant = last;
    any   = ZERO;
    idx   = last;
    // k=4 wraps back to last itself, so a lone repeat requester is still served.
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!any && req[idx]) begin
        grant = idx;
        any   = ONE;
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one memory-controller burst interface among two frame writers and two frame readers.
module mem_burst_arbiter
  import mem_burst_arbiter_pkg::*;
#(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BUSRT_BITS    = 10
) (
  input  logic                       mem_clk,
  input  logic                       rst,

  input  logic [1:0]                 wr_burst_req,
  input  logic [2*BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [2*ADDR_BITS-1:0]     wr_burst_addr,
  input  logic [2*MEM_DATA_BITS-1:0] wr_burst_data,
  output logic [1:0]                 wr_burst_data_req,
  output logic [1:0]                 wr_burst_finish,

  input  logic [1:0]                 rd_burst_req,
  input  logic [2*BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [2*ADDR_BITS-1:0]     rd_burst_addr,
  output logic [1:0]                 rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]   rd_burst_data,
  output logic [1:0]                 rd_burst_finish,

  output logic                       mem_wr_burst_req,
  output logic [BUSRT_BITS-1:0]      mem_wr_burst_len,
  output logic [ADDR_BITS-1:0]       mem_wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0]   mem_wr_burst_data,
  input  logic                       mem_wr_burst_data_req,
  input  logic                       mem_wr_burst_finish,

  output logic                       mem_rd_burst_req,
  output logic [BUSRT_BITS-1:0]      mem_rd_burst_len,
  output logic [ADDR_BITS-1:0]       mem_rd_burst_addr,
  input  logic                       mem_rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_rd_burst_data,
  input  logic                       mem_rd_burst_finish,

  output logic [1:0]                 grant,
  output logic                       busy
);

  state_t                  state, state_nxt;
  logic [1:0]              last_q, grant_q;
  logic [BUSRT_BITS-1:0]   len_q, pick_len;
  logic [ADDR_BITS-1:0]    addr_q, pick_addr;
  logic [3:0]              req_vec;
  logic [1:0]              pick_grant;
  logic                    pick_any;
  logic                    rd_sel, zero_len, done;
  logic                    mem_wr_req_q, mem_rd_req_q;

  assign req_vec = {rd_burst_req, wr_burst_req};

  rr_pick4 u_pick (
    .req   (req_vec),
    .last  (last_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  always_comb begin
    pick_len  = wr_burst_len[0 +: BUSRT_BITS];
    pick_addr = wr_burst_addr[0 +: ADDR_BITS];
    case (pick_grant)
      IDX_W1: begin
        pick_len  = wr_burst_len[BUSRT_BITS +: BUSRT_BITS];
        pick_addr = wr_burst_addr[ADDR_BITS +: ADDR_BITS];
      end
      IDX_R0: begin
        pick_len  = rd_burst_len[0 +: BUSRT_BITS];
        pick_addr = rd_burst_addr[0 +: ADDR_BITS];
      end
      IDX_R1: begin
        pick_len  = rd_burst_len[BUSRT_BITS +: BUSRT_BITS];
        pick_addr = rd_burst_addr[ADDR_BITS +: ADDR_BITS];
      end
      default: ;
    endcase
  end

  assign rd_sel   = is_reader(grant_q);
  assign zero_len = (len_q == '0);
  // A zero-length burst completes on its own; otherwise only the matching direction's finish counts.
  assign done     = (state == S_ISSUE) &&
                    (zero_len || (rd_sel ? mem_rd_burst_finish : mem_wr_burst_finish));

  always_ff @(posedge mem_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pick_any) state_nxt = S_ISSUE;
      S_ISSUE:   if (done)     state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      last_q       <= IDX_R1;
      grant_q      <= IDX_W0;
      len_q        <= '0;
      addr_q       <= '0;
      mem_wr_req_q <= ZERO;
      mem_rd_req_q <= ZERO;
    end else begin
      if (state == S_IDLE && pick_any) begin
        grant_q <= pick_grant;
        len_q   <= pick_len;
        addr_q  <= pick_addr;
      end
      if (state == S_RELEASE) last_q <= grant_q;
      mem_wr_req_q <= (state == S_ISSUE) && !done && !zero_len && !rd_sel;
      mem_rd_req_q <= (state == S_ISSUE) && !done && !zero_len &&  rd_sel;
    end
  end

  always_comb begin
    wr_burst_data_req   = '0;
    wr_burst_finish     = '0;
    rd_burst_data_valid = '0;
    rd_burst_finish     = '0;
    mem_wr_burst_data   = '0;
    if (state == S_ISSUE) begin
      if (rd_sel) begin
        rd_burst_data_valid[grant_q[0]] = mem_rd_burst_data_valid;
        rd_burst_finish[grant_q[0]]     = done;
      end else begin
        wr_burst_data_req[grant_q[0]] = mem_wr_burst_data_req;
        wr_burst_finish[grant_q[0]]   = done;
        mem_wr_burst_data = grant_q[0] ? wr_burst_data[MEM_DATA_BITS +: MEM_DATA_BITS]
                                       : wr_burst_data[0 +: MEM_DATA_BITS];
      end
    end
  end

  assign mem_wr_burst_req  = mem_wr_req_q;
  assign mem_wr_burst_len  = len_q;
  assign mem_wr_burst_addr = addr_q;
  assign mem_rd_burst_req  = mem_rd_req_q;
  assign mem_rd_burst_len  = len_q;
  assign mem_rd_burst_addr = addr_q;
  assign rd_burst_data     = mem_rd_burst_data;
  assign grant             = grant_q;
  assign busy              = (state != S_IDLE);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: directed scenarios plus randomized request mixes.
module tb_mem_burst_arbiter;

  localparam int DW = 32;
  localparam int AW = 23;
  localparam int LW = 10;

  logic            mem_clk = 1'b0;
  logic            rst;
  logic [1:0]      wr_burst_req, rd_burst_req;
  logic [2*LW-1:0] wr_burst_len, rd_burst_len;
  logic [2*AW-1:0] wr_burst_addr, rd_burst_addr;
  logic [2*DW-1:0] wr_burst_data;
  logic [1:0]      wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;
  logic [DW-1:0]   rd_burst_data;
  logic            mem_wr_burst_req, mem_rd_burst_req;
  logic [LW-1:0]   mem_wr_burst_len, mem_rd_burst_len;
  logic [AW-1:0]   mem_wr_burst_addr, mem_rd_burst_addr;
  logic [DW-1:0]   mem_wr_burst_data, mem_rd_burst_data;
  logic            mem_wr_burst_data_req, mem_wr_burst_finish;
  logic            mem_rd_burst_data_valid, mem_rd_burst_finish;
  logic [1:0]      grant;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int last_m;
  int mlen[4];
  int maddr[4];

  always #5 mem_clk = ~mem_clk;

  mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BUSRT_BITS(LW)) dut (
    .mem_clk                 (mem_clk),
    .rst                     (rst),
    .wr_burst_req            (wr_burst_req),
    .wr_burst_len            (wr_burst_len),
    .wr_burst_addr           (wr_burst_addr),
    .wr_burst_data           (wr_burst_data),
    .wr_burst_data_req       (wr_burst_data_req),
    .wr_burst_finish         (wr_burst_finish),
    .rd_burst_req            (rd_burst_req),
    .rd_burst_len            (rd_burst_len),
    .rd_burst_addr           (rd_burst_addr),
    .rd_burst_data_valid     (rd_burst_data_valid),
    .rd_burst_data           (rd_burst_data),
    .rd_burst_finish         (rd_burst_finish),
    .mem_wr_burst_req        (mem_wr_burst_req),
    .mem_wr_burst_len        (mem_wr_burst_len),
    .mem_wr_burst_addr       (mem_wr_burst_addr),
    .mem_wr_burst_data       (mem_wr_burst_data),
    .mem_wr_burst_data_req   (mem_wr_burst_data_req),
    .mem_wr_burst_finish     (mem_wr_burst_finish),
    .mem_rd_burst_req        (mem_rd_burst_req),
    .mem_rd_burst_len        (mem_rd_burst_len),
    .mem_rd_burst_addr       (mem_rd_burst_addr),
    .mem_rd_burst_data_valid (mem_rd_burst_data_valid),
    .mem_rd_burst_data       (mem_rd_burst_data),
    .mem_rd_burst_finish     (mem_rd_burst_finish),
    .grant                   (grant),
    .busy                    (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] req_mask();
    return {rd_burst_req, wr_burst_req};
  endfunction

  // Reference arbitration: first requester found walking forward from the last one served.
  function automatic int rr(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic set_req(input int i, input int len, input int addr);
    mlen[i]  = len;
    maddr[i] = addr;
    if (i < 2) begin
      wr_burst_req[i]               = 1'b1;
      wr_burst_len[i*LW +: LW]      = LW'(len);
      wr_burst_addr[i*AW +: AW]     = AW'(addr);
    end else begin
      rd_burst_req[i-2]             = 1'b1;
      rd_burst_len[(i-2)*LW +: LW]  = LW'(len);
      rd_burst_addr[(i-2)*AW +: AW] = AW'(addr);
    end
  endtask

  task automatic drop_req(input int i);
    if (i < 2) wr_burst_req[i] = 1'b0;
    else       rd_burst_req[i-2] = 1'b0;
  endtask

  // Plays the controller for one burst of requester g and checks every routed signal.
  task automatic do_burst(input int g, input bit spur, input bit middrop);
    int              n, len, addr;
    logic [1:0]      wm, rm;
    logic [2*DW-1:0] wd;
    logic [DW-1:0]   wexp, rdat;
    len  = mlen[g];
    addr = maddr[g];
    wm   = (g < 2)  ? 2'(1 << g)       : 2'b00;
    rm   = (g >= 2) ? 2'(1 << (g - 2)) : 2'b00;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("grant_wait", 64'(busy), 64'(1));
    check("grant", 64'(grant), 64'(g));
    check("issue_lat_wr", 64'(mem_wr_burst_req), 64'(0));
    check("issue_lat_rd", 64'(mem_rd_burst_req), 64'(0));
    if (len == 0) begin
      check("zl_wr_fin", 64'(wr_burst_finish), 64'(wm));
      check("zl_rd_fin", 64'(rd_burst_finish), 64'(rm));
    end else begin
      step();
      check("memreq_wr", 64'(mem_wr_burst_req), 64'(g < 2));
      check("memreq_rd", 64'(mem_rd_burst_req), 64'(g >= 2));
      check("mem_len",  64'(g < 2 ? mem_wr_burst_len : mem_rd_burst_len), 64'(len));
      check("mem_addr", 64'(g < 2 ? mem_wr_burst_addr : mem_rd_burst_addr), 64'(addr));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          #1;
          check("gap_dreq",  64'(wr_burst_data_req),   64'(0));
          check("gap_valid", 64'(rd_burst_data_valid), 64'(0));
          step();
        end
        wd   = {$urandom, $urandom};
        rdat = $urandom;
        wr_burst_data     = wd;
        mem_rd_burst_data = rdat;
        if (g < 2) mem_wr_burst_data_req = 1'b1;
        else       mem_rd_burst_data_valid = 1'b1;
        if (spur && b == 0) mem_rd_burst_finish = 1'b1;
        if (middrop && b == 0) drop_req(g);
        #1;
        wexp = wd[(g % 2)*DW +: DW];
        check("wr_dreq",  64'(wr_burst_data_req),   64'(wm));
        check("rd_valid", 64'(rd_burst_data_valid), 64'(rm));
        if (g < 2) check("wr_data", 64'(mem_wr_burst_data), 64'(wexp));
        else       check("rd_data", 64'(rd_burst_data),     64'(rdat));
        check("hold_req", 64'(g < 2 ? mem_wr_burst_req : mem_rd_burst_req), 64'(1));
        if (spur && b == 0) begin
          check("spur_wfin", 64'(wr_burst_finish), 64'(0));
          check("spur_rfin", 64'(rd_burst_finish), 64'(0));
        end
        step();
        mem_wr_burst_data_req   = 1'b0;
        mem_rd_burst_data_valid = 1'b0;
        mem_rd_burst_finish     = 1'b0;
      end
      if (g < 2) mem_wr_burst_finish = 1'b1;
      else       mem_rd_burst_finish = 1'b1;
      #1;
      check("fin_wr", 64'(wr_burst_finish), 64'(wm));
      check("fin_rd", 64'(rd_burst_finish), 64'(rm));
    end
    step();
    mem_wr_burst_finish = 1'b0;
    mem_rd_burst_finish = 1'b0;
    drop_req(g);
    #1;
    check("rel_busy",  64'(busy),             64'(1));
    check("rel_memwr", 64'(mem_wr_burst_req), 64'(0));
    check("rel_memrd", 64'(mem_rd_burst_req), 64'(0));
    check("rel_fin",   64'({wr_burst_finish, rd_burst_finish}), 64'(0));
    step();
    #1;
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic serve(input bit spur, input bit middrop);
    int g;
    g = rr(last_m, req_mask());
    do_burst(g, spur && (g < 2), middrop);
    last_m = g;
  endtask

  initial begin
    int n;
    logic [3:0] m;
    rst = 1'b1;
    wr_burst_req = '0; rd_burst_req = '0;
    wr_burst_len = '0; rd_burst_len = '0;
    wr_burst_addr = '0; rd_burst_addr = '0;
    wr_burst_data = 64'hdeadbeef_12345678;
    mem_wr_burst_data_req = 1'b0; mem_wr_burst_finish = 1'b0;
    mem_rd_burst_data_valid = 1'b0; mem_rd_burst_finish = 1'b0;
    mem_rd_burst_data = '0;
    repeat (3) step();
    #1;
    check("rst_busy",   64'(busy),              64'(0));
    check("rst_grant",  64'(grant),             64'(0));
    check("rst_memwr",  64'(mem_wr_burst_req),  64'(0));
    check("rst_memrd",  64'(mem_rd_burst_req),  64'(0));
    check("rst_len",    64'(mem_wr_burst_len),  64'(0));
    check("rst_addr",   64'(mem_rd_burst_addr), 64'(0));
    check("rst_wdata",  64'(mem_wr_burst_data), 64'(0));
    check("rst_routes", 64'({wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish}), 64'(0));
    rst = 1'b0;
    last_m = 3;
    step();

    set_req(0, 16, 'h100);
    serve(1'b0, 1'b0);
    set_req(0, 5, 'h200);
    serve(1'b1, 1'b0);
    set_req(3, 8, 'h1234);
    serve(1'b0, 1'b0);
    set_req(1, 0, 'h40);
    serve(1'b0, 1'b0);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last_m = 3;
    set_req(0, 4, 'h10);
    set_req(1, 3, 'h20);
    set_req(2, 2, 'h30);
    set_req(3, 5, 'h40);
    for (int k = 0; k < 4; k++) begin
      serve(1'b0, 1'b0);
      set_req(last_m, mlen[last_m], maddr[last_m]);
    end
    while (req_mask() != 4'b0000) serve(1'b0, 1'b0);

    set_req(2, 6, 'h300);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("mid_busy", 64'(busy), 64'(1));
    step();
    check("mid_memrd", 64'(mem_rd_burst_req), 64'(1));
    mem_rd_burst_data_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_valid", 64'(rd_burst_data_valid), 64'(1));
    step();
    rst = 1'b0;
    #1;
    check("mrst_busy",  64'(busy),                64'(0));
    check("mrst_grant", 64'(grant),               64'(0));
    check("mrst_memrd", 64'(mem_rd_burst_req),    64'(0));
    check("mrst_len",   64'(mem_rd_burst_len),    64'(0));
    check("mrst_addr",  64'(mem_rd_burst_addr),   64'(0));
    check("mrst_valid", 64'(rd_burst_data_valid), 64'(0));
    check("mrst_fin",   64'(rd_burst_finish),     64'(0));
    mem_rd_burst_data_valid = 1'b0;
    last_m = 3;
    serve(1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      m = req_mask();
      for (int i = 0; i < 4; i++)
        if (!m[i] && $urandom_range(0, 1) == 1)
          set_req(i, int'($urandom_range(0, 6)), int'($urandom & 32'h007f_ffff));
      if (req_mask() == 4'b0000)
        set_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom & 32'h007f_ffff));
      serve($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
